pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
//  Sits directly downstream of the rPLL wrapper. Runs on the raw 27 MHz board clock
//  and consumes the PLL LOCK output, driving the PLL RESET input back in a loop.
//  - Produces a clean, lock-qualified system reset.
//  - Produces an SDRAM power-up-done flag that is raised only after the SDRAM
//    power-up wait has elapsed on a stable PLL clock.
//  - On loss of lock, re-arms the PLL and re-sequences.
// PARAMETERS
//  CLK_FREQ_HZ         27_000_000  frequency of clk, used to derive the power-up wait
//  PLL_RST_CYCLES      16          cycles pll_reset is held high per reset pulse
//  LOCK_STABLE_CYCLES  1024        consecutive lock-high cycles required before power-up
//  SDRAM_PWRUP_US      200         SDRAM power-up wait; PWRUP_CYC = CLK_FREQ_HZ/1e6*SDRAM_PWRUP_US
//  WDOG_CYCLES         2_700_000   max WAIT_LOCK dwell before PLL retry (LOCK_WATCHDOG_EN only)
// PORTS
//  clk               in   1  27 MHz board clock; never the PLL output
//  resetn            in   1  synchronous, active-low reset
//  pll_lock          in   1  PLL lock, asynchronous to clk
//  pll_reset         out  1  to PLL RESET, active high
//  sys_resetn        out  1  system reset, active low; clkout-domain consumers resynchronise it
//  sdram_pwrup_done  out  1  high once the SDRAM power-up wait is complete
//  seq_state         out  3  current state encoding, for debug
//  lock_loss_cnt     out  8  saturating count of lock losses in PWRUP/RUN
//  wdog_retry_cnt    out  8  saturating count of watchdog-triggered PLL retries
// BEHAVIOUR
//  - One clock; resetn is synchronous and active-low. All outputs are registered.
//  - resetn low, in any state (including mid-sequence): at the next edge
//    state=PLL_RST, pll_reset=1, sys_resetn=0, sdram_pwrup_done=0, all counters=0.
//  - lock_s is pll_lock passed through a 2-FF synchroniser, i.e. 2 cycles of latency.
//  - PLL_RST: pll_reset=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK;
//    pll_reset=0 from that edge.
//  - WAIT_LOCK: on the first cycle lock_s=1, go to STABLE with stab_cnt=0.
//  - STABLE: stab_cnt increments while lock_s=1.
//    * lock_s=0 -> back to WAIT_LOCK, stab_cnt cleared, no PLL reset, no count.
//    * stab_cnt == LOCK_STABLE_CYCLES-1 with lock_s=1 -> go to PWRUP.
//  - PWRUP: dwell exactly PWRUP_CYC cycles, then go to RUN.
//  - RUN: sys_resetn=1 and sdram_pwrup_done=1, both rising on the same edge as RUN entry.
//  - lock_s=0 in PWRUP or RUN:
//    * go to PLL_RST next edge; sys_resetn=0 and sdram_pwrup_done=0 on that same edge.
//    * lock_loss_cnt += 1, saturating at 255.
//  - Total latency: pll_lock steady high from WAIT_LOCK entry -> RUN entry after
//    2 + 1 + LOCK_STABLE_CYCLES + PWRUP_CYC cycles.
//  - Counter widths are sized by $clog2 of their parameter; no wrap is possible.
// CONFIGURATION
//  LOCK_WATCHDOG_EN defined:
//    - WAIT_LOCK dwell reaching WDOG_CYCLES -> go to PLL_RST.
//    - wdog_retry_cnt += 1, saturating at 255.
//    - The watchdog counter clears on every WAIT_LOCK entry.
//  LOCK_WATCHDOG_EN undefined: WAIT_LOCK waits indefinitely; wdog_retry_cnt is tied to 0.
// STRUCTURE
//  - pll_reset_pkg: state localparams PLL_RST=0, WAIT_LOCK=1, STABLE=2, PWRUP=3, RUN=4,
//    plus the PWRUP_CYC derivation function.
//  - One sub-module: sync_2ff (pll_lock -> lock_s). The FSM and counters live in this module.
// TESTING  (sim params: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, CLK_FREQ_HZ=1e6,
//           SDRAM_PWRUP_US=10, WDOG_CYCLES=50)
//  1. Release resetn, lock high 1 cycle after WAIT_LOCK entry -> pll_reset high 4 cycles;
//     sys_resetn and sdram_pwrup_done rise 2+1+8+10 = 21 cycles after WAIT_LOCK entry.
//  2. Lock glitch low 1 cycle mid-STABLE -> stays out of PLL_RST;
//     RUN is delayed by a full 8-cycle restabilisation; lock_loss_cnt=0.
//  3. Lock drop in RUN -> sys_resetn=0 within 3 cycles; pll_reset high 4 cycles;
//     lock_loss_cnt=1; full re-sequence follows.
//  4. 300 lock drops in RUN -> lock_loss_cnt saturates at 255.
//  5. LOCK_WATCHDOG_EN, lock held low -> pll_reset re-pulses every 4+50 cycles;
//     wdog_retry_cnt increments per retry. Without the macro: no re-pulse, count stays 0.
//  6. resetn low for 1 cycle during PWRUP -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/pll_reset_pkg.sv
// Shared state encoding and helpers for the PLL reset sequencer.
package pll_reset_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      PWRUP     = 3'd3,
      RUN       = 3'd4
   } seq_state_t;

   // SDRAM power-up dwell in clk cycles
   function automatic int pwrup_cyc(input int clk_hz, input int us);
      return (clk_hz / 1_000_000) * us;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hff) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Lock-qualified reset sequencer for the rPLL; LOCK_WATCHDOG_EN adds a WAIT_LOCK
// timeout that re-pulses the PLL reset.
module pll_reset_sequencer
   import pll_reset_pkg::*;
#(
   parameter int CLK_FREQ_HZ        = 27_000_000,
   parameter int PLL_RST_CYCLES     = 16,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int SDRAM_PWRUP_US     = 200,
   parameter int WDOG_CYCLES        = 2_700_000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       pll_lock,
   output logic       pll_reset,
   output logic       sys_resetn,
   output logic       sdram_pwrup_done,
   output logic [2:0] seq_state,
   output logic [7:0] lock_loss_cnt,
   output logic [7:0] wdog_retry_cnt
);

   localparam int PWRUP_CYC = pwrup_cyc(CLK_FREQ_HZ, SDRAM_PWRUP_US);
   localparam int RST_W     = cnt_w(PLL_RST_CYCLES);
   localparam int STAB_W    = cnt_w(LOCK_STABLE_CYCLES);
   localparam int PWR_W     = cnt_w(PWRUP_CYC);
   localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYCLES - 1);
   localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [PWR_W-1:0]  PWR_LAST  = PWR_W'(PWRUP_CYC - 1);

   logic lock_s;

   sync_2ff u_lock_sync (
      .clk    (clk),
      .resetn (resetn),
      .d      (pll_lock),
      .q      (lock_s)
   );

   seq_state_t        state_q, state_d;
   logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
   logic [STAB_W-1:0] stab_cnt_q, stab_cnt_d;
   logic [PWR_W-1:0]  pwr_cnt_q, pwr_cnt_d;
   logic              pll_reset_q, pll_reset_d;
   logic              sys_resetn_q, sys_resetn_d;
   logic              done_q, done_d;
   logic [7:0]        loss_q, loss_d;
`ifdef LOCK_WATCHDOG_EN
   localparam int WDOG_W = cnt_w(WDOG_CYCLES);
   localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
   logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
   logic [7:0]        retry_q, retry_d;
`endif

   always_comb begin
      state_d      = state_q;
      rst_cnt_d    = rst_cnt_q;
      stab_cnt_d   = stab_cnt_q;
      pwr_cnt_d    = pwr_cnt_q;
      pll_reset_d  = pll_reset_q;
      sys_resetn_d = sys_resetn_q;
      done_d       = done_q;
      loss_d       = loss_q;
`ifdef LOCK_WATCHDOG_EN
      wdog_cnt_d   = wdog_cnt_q;
      retry_d      = retry_q;
`endif
      case (state_q)
         PLL_RST: begin
            if (rst_cnt_q == RST_LAST) begin
               state_d     = WAIT_LOCK;
               pll_reset_d = 1'b0;
`ifdef LOCK_WATCHDOG_EN
               wdog_cnt_d  = '0;
`endif
            end else begin
               rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d    = STABLE;
               stab_cnt_d = '0;
            end
`ifdef LOCK_WATCHDOG_EN
            else if (wdog_cnt_q == WDOG_LAST) begin
               state_d     = PLL_RST;
               pll_reset_d = 1'b1;
               rst_cnt_d   = '0;
               retry_d     = sat_inc8(retry_q);
            end else begin
               wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
            end
`endif
         end
         STABLE: begin
            // a lock glitch here only restarts qualification, the PLL is left alone
            if (!lock_s) begin
               state_d    = WAIT_LOCK;
               stab_cnt_d = '0;
`ifdef LOCK_WATCHDOG_EN
               wdog_cnt_d = '0;
`endif
            end else if (stab_cnt_q == STAB_LAST) begin
               state_d   = PWRUP;
               pwr_cnt_d = '0;
            end else begin
               stab_cnt_d = stab_cnt_q + STAB_W'(1);
            end
         end
         PWRUP, RUN: begin
            if (!lock_s) begin
               state_d      = PLL_RST;
               pll_reset_d  = 1'b1;
               sys_resetn_d = 1'b0;
               done_d       = 1'b0;
               rst_cnt_d    = '0;
               loss_d       = sat_inc8(loss_q);
            end else if (state_q == PWRUP) begin
               if (pwr_cnt_q == PWR_LAST) begin
                  state_d      = RUN;
                  sys_resetn_d = 1'b1;
                  done_d       = 1'b1;
               end else begin
                  pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
               end
            end
         end
         default: begin
            state_d      = PLL_RST;
            pll_reset_d  = 1'b1;
            sys_resetn_d = 1'b0;
            done_d       = 1'b0;
            rst_cnt_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= PLL_RST;
         rst_cnt_q    <= '0;
         stab_cnt_q   <= '0;
         pwr_cnt_q    <= '0;
         pll_reset_q  <= 1'b1;
         sys_resetn_q <= 1'b0;
         done_q       <= 1'b0;
         loss_q       <= '0;
`ifdef LOCK_WATCHDOG_EN
         wdog_cnt_q   <= '0;
         retry_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         stab_cnt_q   <= stab_cnt_d;
         pwr_cnt_q    <= pwr_cnt_d;
         pll_reset_q  <= pll_reset_d;
         sys_resetn_q <= sys_resetn_d;
         done_q       <= done_d;
         loss_q       <= loss_d;
`ifdef LOCK_WATCHDOG_EN
         wdog_cnt_q   <= wdog_cnt_d;
         retry_q      <= retry_d;
`endif
      end
   end

   assign pll_reset        = pll_reset_q;
   assign sys_resetn       = sys_resetn_q;
   assign sdram_pwrup_done = done_q;
   assign seq_state        = state_q;
   assign lock_loss_cnt    = loss_q;
`ifdef LOCK_WATCHDOG_EN
   assign wdog_retry_cnt   = retry_q;
`else
   assign wdog_retry_cnt   = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised bench for pll_reset_sequencer against a dwell-time reference model.
module tb_pll_reset_sequencer;

   localparam int PRC = 4;
   localparam int LSC = 8;
   localparam int PWR = 10;
   localparam int WD  = 50;

   logic       clk = 1'b0;
   logic       resetn;
   logic       pll_lock;
   logic       pll_reset;
   logic       sys_resetn;
   logic       sdram_pwrup_done;
   logic [2:0] seq_state;
   logic [7:0] lock_loss_cnt;
   logic [7:0] wdog_retry_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pll_reset_sequencer #(
      .CLK_FREQ_HZ        (1_000_000),
      .PLL_RST_CYCLES     (PRC),
      .LOCK_STABLE_CYCLES (LSC),
      .SDRAM_PWRUP_US     (10),
      .WDOG_CYCLES        (WD)
   ) dut (
      .clk              (clk),
      .resetn           (resetn),
      .pll_lock         (pll_lock),
      .pll_reset        (pll_reset),
      .sys_resetn       (sys_resetn),
      .sdram_pwrup_done (sdram_pwrup_done),
      .seq_state        (seq_state),
      .lock_loss_cnt    (lock_loss_cnt),
      .wdog_retry_cnt   (wdog_retry_cnt)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Model: phase plus the edge it was entered; transitions fire on dwell length.
   int m_st = 0, m_t = 0, m_loss = 0, m_retry = 0, cyc = 0;
   bit p1 = 0, p2 = 0, ls, en = 0;

   always begin
      @(posedge clk);
      ls = p2;
      p2 = p1;
      p1 = pll_lock;
      if (!resetn) begin
         m_st = 0; m_t = cyc; m_loss = 0; m_retry = 0;
         p1 = 0; p2 = 0; en = 1;
      end else begin
         case (m_st)
            0: if (cyc - m_t == PRC) begin m_st = 1; m_t = cyc; end
            1: begin
               if (ls) begin m_st = 2; m_t = cyc; end
`ifdef LOCK_WATCHDOG_EN
               else if (cyc - m_t == WD) begin
                  m_st = 0; m_t = cyc;
                  m_retry = (m_retry < 255) ? m_retry + 1 : 255;
               end
`endif
            end
            2: if (!ls) begin m_st = 1; m_t = cyc; end
               else if (cyc - m_t == LSC) begin m_st = 3; m_t = cyc; end
            3, 4: if (!ls) begin
                  m_st = 0; m_t = cyc;
                  m_loss = (m_loss < 255) ? m_loss + 1 : 255;
               end else if (m_st == 3 && cyc - m_t == PWR) begin
                  m_st = 4; m_t = cyc;
               end
            default: ;
         endcase
      end
      #1;
      if (en) begin
         chk("state",      32'(seq_state),        m_st);
         chk("pll_reset",  32'(pll_reset),        int'(m_st == 0));
         chk("sys_resetn", 32'(sys_resetn),       int'(m_st == 4));
         chk("pwrup_done", 32'(sdram_pwrup_done), int'(m_st == 4));
         chk("loss_cnt",   32'(lock_loss_cnt),    m_loss);
         chk("retry_cnt",  32'(wdog_retry_cnt),   m_retry);
      end
      cyc++;
   end

   task automatic wait_st(input int s, input int budget);
      int k = 0;
      while (32'(seq_state) != s && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (k >= budget) chk("timeout", 32'(seq_state), s);
   endtask

   task automatic pulse_reset();
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   int n, idx, rises;
   bit prev, saw_rst;

   initial begin
      resetn   = 1'b0;
      pll_lock = 1'b0;
      repeat (3) @(negedge clk);

      // 1: reset pulse length and lock-to-RUN latency
      resetn = 1'b1;
      n = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pll_reset) n++; else break;
      end
      chk("t1_rst_len", n, PRC);
      pll_lock = 1'b1;
      idx = 0;
      while (!sys_resetn && idx < 100) begin
         @(negedge clk);
         idx++;
      end
      chk("t1_latency", idx, 2 + 1 + LSC + PWR);
      chk("t1_done", 32'(sdram_pwrup_done), 1);

      // 2: one-cycle glitch during STABLE
      pulse_reset();
      wait_st(2, 100);
      repeat (3) @(negedge clk);
      pll_lock = 1'b0;
      @(negedge clk);
      pll_lock = 1'b1;
      saw_rst = 0;
      for (int i = 0; i < 60 && seq_state != 3'd4; i++) begin
         @(negedge clk);
         if (pll_reset) saw_rst = 1;
      end
      chk("t2_no_pllrst", 32'(saw_rst), 0);
      chk("t2_in_run", 32'(seq_state), 4);
      chk("t2_loss", 32'(lock_loss_cnt), 0);

      // 3: lock drop in RUN
      pll_lock = 1'b0;
      n = 0;
      while (sys_resetn && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("t3_drop_lat", n, 3);
      pll_lock = 1'b1;
      n = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pll_reset) n++; else break;
      end
      chk("t3_rst_len", n, PRC);
      wait_st(4, 100);
      chk("t3_loss", 32'(lock_loss_cnt), 1);

      // 4: loss counter saturation
      for (int i = 0; i < 300; i++) begin
         wait_st(4, 100);
         pll_lock = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
         pll_lock = 1'b1;
         wait_st(0, 20);
      end
      wait_st(4, 100);
      chk("t4_loss_sat", 32'(lock_loss_cnt), 255);

      // 6: reset mid-PWRUP
      pulse_reset();
      wait_st(3, 100);
      repeat ($urandom_range(0, 6)) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      chk("t6_state", 32'(seq_state), 0);
      chk("t6_pll_reset", 32'(pll_reset), 1);
      chk("t6_sys_resetn", 32'(sys_resetn), 0);
      chk("t6_done", 32'(sdram_pwrup_done), 0);
      chk("t6_loss", 32'(lock_loss_cnt), 0);
      resetn = 1'b1;

      // 5: lock held low
      pll_lock = 1'b0;
      pulse_reset();
      rises = 0;
      prev  = pll_reset;
      for (int i = 1; i < 200; i++) begin
         @(negedge clk);
         if (pll_reset && !prev) rises++;
         prev = pll_reset;
      end
`ifdef LOCK_WATCHDOG_EN
      chk("t5_repulses", rises, 3);
      chk("t5_retry", 32'(wdog_retry_cnt), 3);
`else
      chk("t5_repulses", rises, 0);
      chk("t5_retry", 32'(wdog_retry_cnt), 0);
`endif

      // random lock activity with occasional resets
      for (int s = 0; s < 120; s++) begin
         pll_lock = ($urandom_range(0, 3) != 0);
         repeat (pll_lock ? $urandom_range(1, 40) : $urandom_range(1, 4)) @(negedge clk);
         if ($urandom_range(0, 19) == 0) pulse_reset();
      end

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
      $finish;
   end

endmodule
